// File: rtl/serial_adder_ctrl_if.sv
// Handshake/operand bus for serial_adder_ctrl.
//   start/a/b        : request side, driven by the operand source (master)
//   busy/done/sum/carry : status/result side, driven by the adder (slave)
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (output start, a, b, input busy, done, sum, carry);
  modport slave  (input start, a, b, output busy, done, sum, carry);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one sum/carry cell, operand shift registers,
// a bit counter and a start/done handshake. Operands are added LSB-first,
// one bit per clock; sum/carry are registered and only update on entry to DONE.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_adder_ctrl_if (start, a, b -> busy, done, sum, carry)
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);
  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;

  // Sum/carry cell and the result word with the new bit shifted in at the top.
  // The shift form keeps WIDTH=1 legal (r_sr>>1 is just 0).
  logic             s, c_nxt;
  logic [WIDTH-1:0] r_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    s       = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    c_nxt   = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
    r_nxt   = (r_sr_q >> 1) | (WIDTH'(s) << (WIDTH - 1));

    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    carry_d = carry_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          r_sr_d  = '0;
          cnt_d   = '0;
          c_d     = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        c_d    = c_nxt;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_sr_d = r_nxt;
        cnt_d  = cnt_q + CW'(1);
        // Last bit: publish the result directly from the shift-in value so
        // the outputs move exactly once, on entry to DONE.
        if (cnt_q == LAST) begin
          sum_d   = r_nxt;
          carry_d = c_nxt;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1();

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  // Last completed result; outputs must hold this while an add is running.
  logic [7:0] exp_last_sum = 8'h00;
  logic       exp_last_c   = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_sum;
    logic       exp_c;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One add on the WIDTH=8 instance, entered/left at #1 after a posedge with the DUT idle.
  task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_sum, input logic exp_c);
    int lat;
    bit seen;
    bit moved;
    lat = 0; seen = 0; moved = 0;
    bus8.a = a; bus8.b = b; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    chk({nm, "_busy"}, 32'(bus8.busy), 32'd1);
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus8.done) seen = 1;
      else if (bus8.sum !== exp_last_sum || bus8.carry !== exp_last_c) moved = 1;
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'd8);
    chk({nm, "_stable"}, 32'(moved), 32'd0);
    chk({nm, "_sum"}, 32'(bus8.sum), 32'(exp_sum));
    chk({nm, "_carry"}, 32'(bus8.carry), 32'(exp_c));
    exp_last_sum = exp_sum;
    exp_last_c   = exp_c;
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, 32'(bus8.done), 32'd0);
    chk({nm, "_idle"}, 32'(bus8.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [7:0] cap;
    bit bad;
    int first, prev;
    logic [8:0] full;
    logic [7:0] ra, rb;

    vecs[0] = '{8'h05, 8'h03, 8'h08, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[5] = '{8'hC3, 8'h7E, 8'h41, 1'b1};

    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_sum", 32'(bus8.sum), 32'd0);
    chk("rst_carry", 32'(bus8.carry), 32'd0);
    chk("rst_w1", 32'({bus1.busy, bus1.done, bus1.sum, bus1.carry}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table (includes full ripple and carry-cleared-on-load cases)
    for (int i = 0; i < 6; i++)
      run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_c);

    // Randomized against plain arithmetic
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      full = {1'b0, ra} + {1'b0, rb};
      run8($sformatf("rnd%0d", i), ra, rb, full[7:0], full[8]);
    end

    // Start while busy is ignored
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    ndone = 0; cap = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus8.done) begin ndone++; cap = bus8.sum; end
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_sum", 32'(cap), 32'h30);
    chk("busy_start_idle", 32'(bus8.busy), 32'd0);

    // Reset in the middle of SHIFT
    bus8.a = 8'h7F; bus8.b = 8'h01; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'({bus8.busy, bus8.done, bus8.sum, bus8.carry}), 32'd0);
    exp_last_sum = 8'h00; exp_last_c = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    run8("post_rst", 8'h02, 8'h02, 8'h04, 1'b0);

    // start held high: back-to-back adds every WIDTH+2 cycles
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.start = 1'b1;
    ndone = 0; bad = 0; first = -1; prev = -1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clk); #1;
      if (bus8.done) begin
        ndone++;
        if (bus8.sum !== 8'h00 || bus8.carry !== 1'b1) bad = 1;
        if (first < 0) first = cyc;
        else if (cyc - prev != 10) bad = 1;
        prev = cyc;
      end
    end
    bus8.start = 1'b0;
    chk("held_first_done", 32'(first), 32'd9);
    chk("held_ndone", 32'(ndone), 32'd4);
    chk("held_ok", 32'(bad), 32'd0);
    for (int i = 0; i < 20 && bus8.busy; i++) begin @(posedge clk); #1; end
    chk("held_drain", 32'(bus8.busy), 32'd0);
    exp_last_sum = 8'h00; exp_last_c = 1'b1;

    // WIDTH=1 sweep
    for (int k = 0; k < 4; k++) begin
      int lat;
      bit seen;
      lat = 0; seen = 0;
      bus1.a = 1'(k >> 1); bus1.b = 1'(k); bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
        @(posedge clk); #1;
        lat++;
        if (bus1.done) seen = 1;
      end
      chk($sformatf("w1_%0d_lat", k), 32'(lat), 32'd1);
      chk($sformatf("w1_%0d_sum", k), 32'(bus1.sum), 32'((k >> 1) ^ (k & 1)));
      chk($sformatf("w1_%0d_carry", k), 32'(bus1.carry), 32'((k >> 1) & (k & 1)));
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
